// File: rtl/eth_vlg_pkg.sv
// Shared Ethernet types and constants for the eth_vlg switch/MAC code.
// Holds the TX arbiter state encoding and the default inter-frame gap.
package eth_vlg_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_XFER,
    ARB_FLUSH,
    ARB_GAP
  } arb_state_t;

  localparam int unsigned ETH_IFG_DEFAULT = 12;

endpackage

// File: rtl/eth_vlg_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr_i, wrapping modulo N.
module eth_vlg_rr_pick #(
  parameter int unsigned N    = 3,
  parameter int unsigned PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [PtrW-1:0] win_o,
  output logic            any_o
);

  localparam logic [PtrW:0] NumSrc = (PtrW + 1)'(N);

  logic [PtrW:0] idx;

  // Scan from the farthest offset down so the nearest requester after ptr_i wins.
  always_comb begin
    win_o = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int d = int'(N); d >= 1; d--) begin
      idx = {1'b0, ptr_i} + (PtrW + 1)'(d);
      if (idx >= NumSrc) begin
        idx = idx - NumSrc;
      end
      if (req_i[idx[PtrW-1:0]]) begin
        win_o = idx[PtrW-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_vlg_tx_arb.sv
// Packet-level round-robin arbiter sharing one byte-wide TX path among N frame sources,
// with inter-frame gap, grant timeout and max-length truncation.
module eth_vlg_tx_arb
  import eth_vlg_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned IFG     = 10,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned GNT_TMO = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  output logic [N-1:0]   acc_o,
  input  logic [N*8-1:0] din_i,
  input  logic [N-1:0]   vin_i,
  output logic [7:0]     dout_o,
  output logic           vout_o,
  output logic           busy_o,
  output logic           abort_o
);

  localparam int unsigned PtrW = $clog2(N);
  localparam int unsigned LenW = $clog2(MAX_LEN + 2);
  localparam int unsigned GapW = (IFG > 1) ? $clog2(IFG) : 1;
  localparam int unsigned TmoW = (GNT_TMO > 1) ? $clog2(GNT_TMO) : 1;

  arb_state_t      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win_q, win_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [7:0]      dout_q, dout_d;
  logic            vout_q, vout_d;
  logic            abort_q, abort_d;
  logic [LenW-1:0] len_q, len_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic [PtrW-1:0] pick_win;
  logic            pick_any;
  logic [7:0]      din_arr [N];
  logic            vin_w;
  logic            req_w;
  logic [7:0]      din_w;

  eth_vlg_rr_pick #(
    .N    (N),
    .PtrW (PtrW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .any_o (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      din_arr[i] = din_i[8*i +: 8];
    end
  end

  assign vin_w = vin_i[win_q];
  assign req_w = req_i[win_q];
  assign din_w = din_arr[win_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    abort_d = 1'b0;
    len_d   = len_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d         = ARB_GRANT;
          win_d           = pick_win;
          ptr_d           = pick_win;
          acc_d           = '0;
          acc_d[pick_win] = 1'b1;
          len_d           = '0;
          tmo_d           = '0;
        end
      end
      ARB_GRANT: begin
        // First valid byte beats both withdrawal and timeout in the same cycle.
        if (vin_w) begin
          state_d = ARB_XFER;
          dout_d  = din_w;
          vout_d  = 1'b1;
          len_d   = LenW'(1);
        end else if (!req_w) begin
          state_d = ARB_IDLE;
          acc_d   = '0;
        end else if (tmo_q == TmoW'(GNT_TMO - 1)) begin
          state_d = ARB_GAP;
          acc_d   = '0;
          abort_d = 1'b1;
          gap_d   = GapW'(IFG - 1);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ARB_XFER: begin
        if (!vin_w) begin
          state_d = ARB_GAP;
          acc_d   = '0;
          gap_d   = GapW'(IFG - 1);
        end else if (len_q == LenW'(MAX_LEN)) begin
          // Oversize: drop this byte and the rest, keep the grant until the source lets go.
          state_d = ARB_FLUSH;
          abort_d = 1'b1;
        end else begin
          dout_d = din_w;
          vout_d = 1'b1;
          len_d  = len_q + 1'b1;
        end
      end
      ARB_FLUSH: begin
        if (!vin_w) begin
          state_d = ARB_GAP;
          acc_d   = '0;
          gap_d   = GapW'(IFG - 1);
        end
      end
      ARB_GAP: begin
        if (gap_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        acc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      ptr_q   <= PtrW'(N - 1);
      win_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      abort_q <= 1'b0;
      len_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      abort_q <= abort_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
    end
  end

  assign acc_o   = acc_q;
  assign dout_o  = dout_q;
  assign vout_o  = vout_q;
  assign abort_o = abort_q;
  assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_eth_vlg_tx_arb.sv
// Bench for eth_vlg_tx_arb: directed scenarios with literal expectations, then random traffic,
// all cross-checked every cycle against a procedural frame-level model.
module tb_eth_vlg_tx_arb;

  localparam int unsigned N       = 3;
  localparam int unsigned IFG     = 10;
  localparam int unsigned MAX_LEN = 1518;
  localparam int unsigned GNT_TMO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, vin, acc;
  logic [N*8-1:0] din;
  logic [7:0]     dout;
  logic           vout, busy, abort;

  eth_vlg_tx_arb #(
    .N       (N),
    .IFG     (IFG),
    .MAX_LEN (MAX_LEN),
    .GNT_TMO (GNT_TMO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .acc_o   (acc),
    .din_i   (din),
    .vin_i   (vin),
    .dout_o  (dout),
    .vout_o  (vout),
    .busy_o  (busy),
    .abort_o (abort)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
  endtask

  // Reference model: walks through one frame's life per loop pass, sampling inputs at the edge.
  logic [N-1:0]   exp_acc, s_req, s_vin;
  logic [N*8-1:0] s_din;
  logic           exp_vout, exp_busy, exp_abort;
  logic [7:0]     exp_dout;
  int             m_ptr;

  task automatic m_edge(output bit r);
    @(posedge clk);
    s_req = req;
    s_vin = vin;
    s_din = din;
    r     = rst;
    if (r) begin
      exp_acc = '0; exp_vout = 0; exp_busy = 0; exp_abort = 0; exp_dout = '0;
      m_ptr   = N - 1;
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int d = 1; d <= int'(N); d++) if (r[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  initial begin : model
    bit r, served, to, trunc;
    int w, n, k;
    exp_acc = '0; exp_vout = 0; exp_busy = 0; exp_abort = 0; exp_dout = '0; m_ptr = N - 1;
    forever begin
      m_edge(r);
      if (r || s_req == '0) continue;
      w = pick(s_req, m_ptr);
      m_ptr = w;
      exp_acc = '0; exp_acc[w] = 1'b1; exp_busy = 1; exp_abort = 0; exp_vout = 0;
      served = 0; to = 0; k = 0;
      forever begin
        m_edge(r);
        if (r) break;
        if (s_vin[w]) begin
          exp_dout = s_din[8*w +: 8]; exp_vout = 1; served = 1;
          break;
        end
        if (!s_req[w]) begin
          exp_acc = '0; exp_busy = 0;
          break;
        end
        k++;
        if (k == int'(GNT_TMO)) begin
          exp_acc = '0; exp_abort = 1; to = 1;
          break;
        end
      end
      if (r || (!served && !to)) continue;
      if (served) begin
        n = 1; trunc = 0;
        forever begin
          m_edge(r);
          if (r) break;
          exp_abort = 0;
          if (!s_vin[w]) begin
            exp_vout = 0; exp_acc = '0;
            break;
          end
          if (n == int'(MAX_LEN)) begin
            exp_vout = 0; exp_abort = 1; trunc = 1;
            break;
          end
          exp_dout = s_din[8*w +: 8]; exp_vout = 1; n++;
        end
        if (r) continue;
        if (trunc) begin
          forever begin
            m_edge(r);
            if (r) break;
            exp_abort = 0;
            if (!s_vin[w]) begin
              exp_acc = '0;
              break;
            end
          end
          if (r) continue;
        end
      end
      for (int g = 0; g < int'(IFG); g++) begin
        m_edge(r);
        if (r) break;
        exp_abort = 0;
        if (g == int'(IFG) - 1) exp_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("acc", acc, exp_acc);
      chk("vout", vout, exp_vout);
      chk("busy", busy, exp_busy);
      chk("abort", abort, exp_abort);
      if (exp_vout) chk("dout", dout, exp_dout);
    end
  end

  // Running statistics for the literal per-scenario expectations.
  int           mon_bytes = 0, mon_abort = 0, mon_gap = 0;
  int           mon_grants[$];
  logic [7:0]   mon_q[$];
  logic [N-1:0] acc_prev = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      if (vout) begin
        mon_bytes++;
        mon_q.push_back(dout);
      end
      if (abort) mon_abort++;
      if (busy && !vout && acc == '0) mon_gap++;
      if (acc != '0 && acc_prev == '0) begin
        for (int i = 0; i < int'(N); i++) if (acc[i]) mon_grants.push_back(i);
      end
      acc_prev = acc;
    end
  end

  logic [7:0] sent_q[$];

  task automatic send(input int w, input int len, output int lost);
    logic [7:0] b;
    lost = 0;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      vin[w] = 1'b1;
      din[8*w +: 8] = b;
      sent_q.push_back(b);
      if (!acc[w]) lost++;
      @(negedge clk);
    end
    if (!acc[w]) lost++;
    vin[w] = 1'b0;
  endtask

  task automatic wait_acc(output int w);
    int c;
    c = 0;
    w = 0;
    @(negedge clk);
    while (acc == '0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (acc == '0) begin
      n_chk++;
      $display("FAIL wait_acc @%0t: no grant within %0d cycles, want a grant", $time, c);
    end else begin
      for (int i = 0; i < int'(N); i++) if (acc[i]) w = i;
    end
  endtask

  // Random traffic: per-source request/frame behaviour, including lazy and withdrawing sources.
  int st[N], dly[N], flen[N], beh[N], pre[N], sent[N];
  bit gseen[N];

  task automatic drive_rand();
    for (int i = 0; i < int'(N); i++) begin
      case (st[i])
        0: begin
          req[i] = 1'b0;
          vin[i] = ($urandom_range(7) == 0);
          din[8*i +: 8] = 8'($urandom);
          if (dly[i] > 0) dly[i]--;
          else begin
            req[i] = 1'b1; vin[i] = 1'b0; st[i] = 1; gseen[i] = 0;
            beh[i] = $urandom_range(9); flen[i] = $urandom_range(1, 48);
            pre[i] = $urandom_range(0, 4);
          end
        end
        1: begin
          if (acc[i]) gseen[i] = 1;
          if (gseen[i] && !acc[i]) begin
            req[i] = 1'b0; st[i] = 0; dly[i] = $urandom_range(0, 30);
          end else if (gseen[i] && beh[i] == 1) begin
            if (pre[i] > 0) pre[i]--;
            else begin
              req[i] = 1'b0; st[i] = 0; dly[i] = $urandom_range(0, 30);
            end
          end else if (gseen[i] && beh[i] != 0) begin
            if (pre[i] > 0) pre[i]--;
            else begin
              vin[i] = 1'b1; din[8*i +: 8] = 8'($urandom); sent[i] = 1; st[i] = 2;
            end
          end
        end
        default: begin
          if (sent[i] < flen[i]) begin
            din[8*i +: 8] = 8'($urandom); sent[i]++;
          end else begin
            vin[i] = 1'b0; req[i] = 1'b0; st[i] = 0; dly[i] = $urandom_range(0, 30);
          end
        end
      endcase
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, lost, b0, a0, g0, q0, s0, gq0, bad, c;
    rst = 1'b1; req = '0; vin = '0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_vout", vout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    chk("rst_dout", dout, 0);
    rst = 1'b0;
    chk_on = 1'b1;

    // 1: single source, 60-byte frame three cycles after the grant
    b0 = mon_bytes; a0 = mon_abort; g0 = mon_gap; q0 = mon_q.size(); s0 = sent_q.size();
    req = 3'b010;
    @(negedge clk);
    chk("t1_acc", acc, 3'b010);
    repeat (2) @(negedge clk);
    send(1, 60, lost);
    req = '0;
    repeat (15) @(negedge clk);
    chk("t1_bytes", mon_bytes - b0, 60);
    chk("t1_gap", mon_gap - g0, IFG);
    chk("t1_abort", mon_abort - a0, 0);
    chk("t1_lost", lost, 0);
    bad = 0;
    for (int k = 0; k < 60; k++) if (mon_q[q0 + k] !== sent_q[s0 + k]) bad++;
    chk("t1_data", bad, 0);

    // 2: everyone requesting continuously, fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b0 = mon_bytes; a0 = mon_abort; g0 = mon_gap; gq0 = mon_grants.size();
    req = 3'b111;
    for (int f = 0; f < 6; f++) begin
      wait_acc(w);
      send(w, 64, lost);
      chk("t2_lost", lost, 0);
    end
    req = '0;
    repeat (15) @(negedge clk);
    for (int f = 0; f < 6; f++) chk("t2_order", mon_grants[gq0 + f], f % 3);
    chk("t2_bytes", mon_bytes - b0, 6 * 64);
    chk("t2_gap", mon_gap - g0, 6 * IFG);
    chk("t2_abort", mon_abort - a0, 0);

    // 3: source 2 granted but never sends; source 0 waits behind it
    a0 = mon_abort; g0 = mon_gap;
    req = 3'b100;
    wait_acc(w);
    chk("t3_acc", acc, 3'b100);
    req[0] = 1'b1;
    c = 1;
    forever begin
      @(negedge clk);
      if (!acc[2] || c >= 200) break;
      c++;
    end
    chk("t3_tmo_cycles", c, GNT_TMO);
    chk("t3_abort_on", abort, 1);
    req[2] = 1'b0;
    @(negedge clk);
    chk("t3_abort_off", abort, 0);
    wait_acc(w);
    chk("t3_next", acc, 3'b001);
    chk("t3_gap", mon_gap - g0, IFG);
    chk("t3_abort_cnt", mon_abort - a0, 1);
    send(0, 5, lost);
    req = '0;
    repeat (15) @(negedge clk);

    // 4: oversize frame from source 0, source 1 pending
    req = 3'b001;
    wait_acc(w);
    chk("t4_acc", acc, 3'b001);
    req[1] = 1'b1;
    b0 = mon_bytes; a0 = mon_abort; g0 = mon_gap;
    send(0, 1600, lost);
    req[0] = 1'b0;
    wait_acc(w);
    chk("t4_next", acc, 3'b010);
    chk("t4_bytes", mon_bytes - b0, MAX_LEN);
    chk("t4_abort", mon_abort - a0, 1);
    chk("t4_gap", mon_gap - g0, IFG);
    chk("t4_held", lost, 0);
    send(1, 8, lost);
    req = '0;
    repeat (15) @(negedge clk);

    // 5: request withdrawn while granted
    a0 = mon_abort; g0 = mon_gap;
    req = 3'b010;
    @(negedge clk);
    chk("t5_acc", acc, 3'b010);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_acc_off", acc, 0);
    req = 3'b101;
    @(negedge clk);
    chk("t5_next", acc, 3'b100);
    chk("t5_abort", mon_abort - a0, 0);
    chk("t5_gap", mon_gap - g0, 0);
    send(2, 4, lost);
    req = '0;
    repeat (15) @(negedge clk);

    // 6: reset lands in the middle of a frame
    req = 3'b001;
    wait_acc(w);
    for (int k = 0; k < 30; k++) begin
      vin[0] = 1'b1;
      din[7:0] = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("t6_vout", vout, 0);
    chk("t6_acc", acc, 0);
    chk("t6_busy", busy, 0);
    chk("t6_dout", dout, 0);
    rst = 1'b0; vin = '0; req = 3'b011;
    wait_acc(w);
    chk("t6_first", acc, 3'b001);
    send(0, 6, lost);
    req[0] = 1'b0;
    wait_acc(w);
    send(w, 6, lost);
    req = '0;
    repeat (15) @(negedge clk);

    // Random traffic
    for (int i = 0; i < int'(N); i++) begin
      st[i] = 0; dly[i] = $urandom_range(0, 20);
    end
    for (int t = 0; t < 8000; t++) begin
      drive_rand();
      @(negedge clk);
    end
    req = '0; vin = '0;
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
